gpu_pixel_writer: RTL and testbench

- Consumer of the arbitrated pixel stream from the GPU output decoder (line/fill engines).
- Clips off-screen pixels and computes the linear framebuffer address y*SCREEN_WIDTH+x.
- Buffers pixels in a small FIFO and issues one write per pixel to the SRAM controller using a req/ack handshake.
- Decouples the rasterizing engines from memory stalls through ready back-pressure.

---
 rtl/gpu_pixel_writer_pkg.sv | 20 ++
 rtl/gpu_pixel_fifo.sv | 63 ++++++
 rtl/gpu_pixel_writer.sv | 126 ++++++++++++
 tb/tb_gpu_pixel_writer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pixel_writer_pkg.sv
// Shared GPU definitions: pixel field widths, screen geometry and the
// framebuffer write record.
package gpu_pixel_writer_pkg;

  localparam int unsigned WIDTH_BITS    = 10;
  localparam int unsigned HEIGHT_BITS   = 9;
  localparam int unsigned CHANNEL_BITS  = 8;
  localparam int unsigned COLOR_BITS    = 3 * CHANNEL_BITS;

  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;
  localparam int unsigned FB_ADDR_BITS  = 19;

  // One framebuffer write: linear word address plus {r,g,b} colour.
  typedef struct packed {
    logic [FB_ADDR_BITS-1:0] addr;
    logic [COLOR_BITS-1:0]   color;
  } pixel_write_t;

endpackage

// File: rtl/gpu_pixel_fifo.sv
// Small synchronous FIFO with a registered occupancy count and a
// combinational head read port.
module gpu_pixel_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0] count_q;
  logic                push_ok, pop_ok;

  // Overflow/underflow requests are ignored rather than corrupting state.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign full  = (count_q == CNT_BITS'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == PTR_BITS'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_BITS'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == PTR_BITS'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_BITS'(1);
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + CNT_BITS'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - CNT_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/gpu_pixel_writer.sv
// Pixel writer: clips off-screen pixels, computes the linear framebuffer
// address, buffers writes and drives a req/ack write port to the SRAM
// controller.
module gpu_pixel_writer #(
  parameter int unsigned SCREEN_WIDTH  = gpu_pixel_writer_pkg::SCREEN_WIDTH,
  parameter int unsigned SCREEN_HEIGHT = gpu_pixel_writer_pkg::SCREEN_HEIGHT,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned ADDR_BITS     = gpu_pixel_writer_pkg::FB_ADDR_BITS
) (
  input  logic                                       clk,
  input  logic                                       n_rst,
  input  logic                                       pixel_valid_i,
  input  logic [gpu_pixel_writer_pkg::WIDTH_BITS-1:0]  x_i,
  input  logic [gpu_pixel_writer_pkg::HEIGHT_BITS-1:0] y_i,
  input  logic [gpu_pixel_writer_pkg::COLOR_BITS-1:0]  color_i,
  output logic                                       pixel_ready_o,
  output logic                                       mem_req_o,
  output logic [ADDR_BITS-1:0]                       mem_addr_o,
  output logic [gpu_pixel_writer_pkg::COLOR_BITS-1:0]  mem_wdata_o,
  input  logic                                       mem_ack_i,
  output logic                                       busy_o,
  output logic [15:0]                                drop_cnt_o
);

  import gpu_pixel_writer_pkg::*;

  localparam int unsigned CNT_BITS   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_BITS = ADDR_BITS + COLOR_BITS;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  // FIFO record sized by this instance's address width.
  typedef struct packed {
    logic [ADDR_BITS-1:0]  addr;
    logic [COLOR_BITS-1:0] color;
  } entry_t;

  entry_t              push_entry, head_entry;
  logic                in_xfer, in_bounds, push, pop;
  logic                fifo_full, fifo_empty;
  logic [CNT_BITS-1:0] fifo_count;
  logic [0:0]          state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [COLOR_BITS-1:0] wdata_q;
  logic [15:0]         drop_q;

  // Ready depends only on registered occupancy, never on the same-cycle pop.
  assign pixel_ready_o = ~fifo_full;
  assign in_xfer       = pixel_valid_i & pixel_ready_o;
  assign in_bounds     = (32'(x_i) < SCREEN_WIDTH) && (32'(y_i) < SCREEN_HEIGHT);
  assign push          = in_xfer & in_bounds;

  assign push_entry.addr  = ADDR_BITS'(32'(y_i) * SCREEN_WIDTH + 32'(x_i));
  assign push_entry.color = color_i;

  gpu_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_BITS)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output FSM next state and pop: load in IDLE, or reload on ack for back-to-back writes.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack_i) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and the held write address/data; values persist through IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        addr_q  <= head_entry.addr;
        wdata_q <= head_entry.color;
      end
    end
  end

  // Saturating count of accepted but off-screen pixels.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      drop_q <= '0;
    end else if (in_xfer && !in_bounds && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign mem_req_o   = (state_q == ST_REQ);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (fifo_count != '0) | mem_req_o;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Bench for gpu_pixel_writer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_gpu_pixel_writer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        pixel_valid;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [23:0] color;
  logic        ack;
  logic        pixel_ready, mem_req, busy;
  logic [18:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  gpu_pixel_writer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .pixel_valid_i (pixel_valid),
    .x_i           (x),
    .y_i           (y),
    .color_i       (color),
    .pixel_ready_o (pixel_ready),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_ack_i     (ack),
    .busy_o        (busy),
    .drop_cnt_o    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Reference model: a queue of buffered writes, the write on offer, and the log of
  // writes the controller has acknowledged.
  typedef struct packed {
    int unsigned addr;
    int unsigned color;
  } wr_t;

  wr_t         fq[$];
  wr_t         wlog[$];
  bit          m_req  = 1'b0;
  int unsigned m_addr = 0;
  int unsigned m_data = 0;
  int unsigned m_drop = 0;

  always @(posedge clk or negedge n_rst) begin
    wr_t e;
    bit  rdy;
    if (!n_rst) begin
      fq.delete();
      m_req  = 1'b0;
      m_addr = 0;
      m_data = 0;
      m_drop = 0;
    end else begin
      rdy = (fq.size() != DEPTH);
      if (m_req && ack) begin
        e.addr  = m_addr;
        e.color = m_data;
        wlog.push_back(e);
      end
      if (!m_req || ack) begin
        if (fq.size() != 0) begin
          e      = fq.pop_front();
          m_addr = e.addr;
          m_data = e.color;
          m_req  = 1'b1;
        end else begin
          m_req = 1'b0;
        end
      end
      if (pixel_valid && rdy) begin
        if (int'(x) < 640 && int'(y) < 480) begin
          e.addr  = int'(y) * 640 + int'(x);
          e.color = int'(color);
          fq.push_back(e);
        end else if (m_drop != 65535) begin
          m_drop++;
        end
      end
    end
  end

  // Every cycle, the DUT outputs must match the model.
  always @(negedge clk) begin
    check("cyc_req", mem_req, m_req);
    check("cyc_addr", mem_addr, m_addr);
    check("cyc_wdata", mem_wdata, m_data);
    check("cyc_ready", pixel_ready, (fq.size() != DEPTH));
    check("cyc_busy", busy, (fq.size() != 0) || m_req);
    check("cyc_drop", drop_cnt, m_drop);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      step();
      n++;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic check_wr(input string name, input int idx, input int unsigned a,
                          input int unsigned c);
    if (idx < wlog.size()) begin
      check({name, "_addr"}, wlog[idx].addr, a);
      check({name, "_data"}, wlog[idx].color, c);
    end else begin
      check({name, "_count"}, wlog.size(), idx + 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int i;
    int cyc;
    bit rdy;

    n_rst = 1'b0;
    pixel_valid = 1'b0;
    x = '0;
    y = '0;
    color = '0;
    ack = 1'b0;
    repeat (3) step();
    n_rst = 1'b1;
    step();
    check("rst_ready", pixel_ready, 1);
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);

    // Single pixel with a stalled controller.
    wlog.delete();
    x = 3; y = 2; color = 24'hFF0000; pixel_valid = 1'b1;
    step();
    pixel_valid = 1'b0;
    check("s1_req_after_e0", mem_req, 0);
    check("s1_busy_after_e0", busy, 1);
    step();
    check("s1_req_after_e1", mem_req, 1);
    check("s1_addr", mem_addr, 1283);
    check("s1_wdata", mem_wdata, 24'hFF0000);
    repeat (4) begin
      step();
      check("s1_hold_req", mem_req, 1);
      check("s1_hold_addr", mem_addr, 1283);
      check("s1_hold_wdata", mem_wdata, 24'hFF0000);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("s1_req_fall", mem_req, 0);
    check("s1_busy_fall", busy, 0);
    check("s1_nwr", wlog.size(), 1);
    check_wr("s1_wr0", 0, 1283, 24'hFF0000);

    // Corner pixels with ack held high: back-to-back requests.
    wlog.delete();
    ack = 1'b1;
    x = 0; y = 0; color = 24'h00FF00; pixel_valid = 1'b1;
    step();
    x = 639; y = 479; color = 24'h0000FF;
    step();
    pixel_valid = 1'b0;
    check("s2_req_a", mem_req, 1);
    check("s2_addr_a", mem_addr, 0);
    step();
    check("s2_req_b", mem_req, 1);
    check("s2_addr_b", mem_addr, 307199);
    check("s2_wdata_b", mem_wdata, 24'h0000FF);
    step();
    check("s2_req_end", mem_req, 0);
    ack = 1'b0;
    check("s2_nwr", wlog.size(), 2);
    check_wr("s2_wr0", 0, 0, 24'h00FF00);
    check_wr("s2_wr1", 1, 307199, 24'h0000FF);

    // Six pixels into a stalled controller: FIFO fills, ready drops.
    wlog.delete();
    i = 0;
    cyc = 0;
    while (i < 5 && cyc < 30) begin
      x = 10'(10 + i); y = 5; color = 24'(i + 1); pixel_valid = 1'b1;
      rdy = pixel_ready;
      step();
      if (rdy) i++;
      cyc++;
    end
    check("s3_accepted", i, 5);
    check("s3_ready_full", pixel_ready, 0);
    check("s3_busy_full", busy, 1);
    check("s3_req_full", mem_req, 1);
    check("s3_addr_full", mem_addr, 3210);
    x = 15; y = 5; color = 24'd6;
    repeat (3) begin
      step();
      check("s3_stall_ready", pixel_ready, 0);
    end
    ack = 1'b1;
    while (i < 6 && cyc < 60) begin
      rdy = pixel_ready;
      step();
      if (rdy) i++;
      cyc++;
    end
    pixel_valid = 1'b0;
    check("s3_accepted_all", i, 6);
    wait_idle("s3", 20);
    ack = 1'b0;
    check("s3_nwr", wlog.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check_wr("s3_wr", k, 3210 + k, k + 1);
    end

    // Clipped pixels and drop counter saturation.
    wlog.delete();
    x = 640; y = 0; pixel_valid = 1'b1;
    step();
    x = 0; y = 480;
    step();
    pixel_valid = 1'b0;
    check("s4_drop2", drop_cnt, 2);
    check("s4_req", mem_req, 0);
    check("s4_ready", pixel_ready, 1);
    check("s4_busy", busy, 0);
    step();
    check("s4_req_later", mem_req, 0);
    x = 640; y = 0; pixel_valid = 1'b1;
    repeat (65537) step();
    pixel_valid = 1'b0;
    step();
    check("s4_drop_sat", drop_cnt, 16'hFFFF);
    check("s4_nwr", wlog.size(), 0);

    // Asynchronous reset with one write in flight and three buffered.
    wlog.delete();
    for (int k = 0; k < 4; k++) begin
      x = 10'(20 + k); y = 7; color = 24'(k); pixel_valid = 1'b1;
      step();
    end
    pixel_valid = 1'b0;
    check("s5_req_pre", mem_req, 1);
    check("s5_busy_pre", busy, 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("s5_req_rst", mem_req, 0);
    check("s5_busy_rst", busy, 0);
    check("s5_drop_rst", drop_cnt, 0);
    check("s5_addr_rst", mem_addr, 0);
    step();
    step();
    n_rst = 1'b1;
    repeat (3) begin
      step();
      check("s5_no_stale_req", mem_req, 0);
      check("s5_no_stale_busy", busy, 0);
    end
    check("s5_nwr_stale", wlog.size(), 0);
    ack = 1'b1;
    x = 1; y = 1; color = 24'h123456; pixel_valid = 1'b1;
    step();
    pixel_valid = 1'b0;
    wait_idle("s5", 20);
    ack = 1'b0;
    check("s5_nwr", wlog.size(), 1);
    check_wr("s5_wr0", 0, 641, 24'h123456);

    // Spurious acks while idle change nothing.
    wlog.delete();
    for (int k = 0; k < 4; k++) begin
      ack = k[0];
      step();
      check("s6_req_idle", mem_req, 0);
      check("s6_busy_idle", busy, 0);
      check("s6_ready_idle", pixel_ready, 1);
    end
    ack = 1'b0;
    x = 7; y = 3; color = 24'hABCDEF; pixel_valid = 1'b1;
    step();
    pixel_valid = 1'b0;
    step();
    check("s6_req", mem_req, 1);
    check("s6_addr", mem_addr, 1927);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("s6_req_fall", mem_req, 0);
    check("s6_nwr", wlog.size(), 1);
    check_wr("s6_wr0", 0, 1927, 24'hABCDEF);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
